// File: rtl/c_route_split8_mmu_if.sv
// Bundled-data channel bundle for the 1-to-8 MMU response splitter.
// Upstream: i_drive/i_data/o_free. Downstream port k: o_drive[k]/o_data[k]/i_free[k].
interface c_route_split8_mmu_if #(
  parameter int NUM_PORTS  = 8,
  parameter int DATA_WIDTH = 88
);
  logic                                 i_drive;
  logic [DATA_WIDTH-1:0]                i_data;
  logic                                 o_free;
  logic [NUM_PORTS-1:0]                 o_drive;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] o_data;
  logic [NUM_PORTS-1:0]                 i_free;

  modport master (output i_drive, i_data, i_free, input o_free, o_drive, o_data);
  modport slave  (input i_drive, i_data, i_free, output o_free, o_drive, o_data);
endinterface

// File: rtl/c_route_split8_mmu.sv
// Clockless click-element splitter: one input stage steers each token to one of eight output stages.
// Define MMU_SPLIT_BCAST_EN to treat i_data[SEL_LSB+3] as a broadcast flag (all ports, joined release).
module c_route_split8_mmu #(
  parameter int NUM_PORTS  = 8,
  parameter int DATA_WIDTH = 88,
  parameter int SEL_LSB    = 0,
  parameter int DLY_IN     = 14,
  parameter int DLY_FREE   = 1
) (
  input logic                 rstn,
  c_route_split8_mmu_if.slave bus
);

  logic                  in_ph, out_ph, clr_ph, full1;
  logic                  req, rel_raw, rel;
  logic [DATA_WIDTH-1:0] r_in;
  logic [NUM_PORTS-1:0]  r_sel, fire, full, taken;
  logic [DLY_IN:0]       dly_in;
  logic [DLY_FREE:0]     dly_free;

  function automatic logic [NUM_PORTS-1:0] sel_dec(input logic [DATA_WIDTH-1:0] d);
    logic [NUM_PORTS-1:0] s;
    s = '0;
    s[d[SEL_LSB+:3]] = 1'b1;
`ifdef MMU_SPLIT_BCAST_EN
    if (d[SEL_LSB+3]) s = '1;
`endif
    return s;
  endfunction

  // Input stage: o_free only rises once the stage is empty, so a legal i_drive edge always finds it empty.
  always_ff @(posedge bus.i_drive or negedge rstn) begin
    if (!rstn) begin
      in_ph <= 1'b0;
      r_in  <= '0;
      r_sel <= '0;
    end else begin
      in_ph <= ~in_ph;
      r_in  <= bus.i_data;
      r_sel <= sel_dec(bus.i_data);
    end
  end

  always_ff @(posedge rel or negedge rstn) begin
    if (!rstn) out_ph <= 1'b0;
    else       out_ph <= ~out_ph;
  end

  // o_free returns to zero when upstream drops i_drive
  always_ff @(negedge bus.i_drive or negedge rstn) begin
    if (!rstn) clr_ph <= 1'b0;
    else       clr_ph <= ~clr_ph;
  end

  assign full1      = in_ph ^ out_ph;
  assign bus.o_free = out_ph ^ clr_ph;

  // Matched-delay lines; taps become physical delay cells at implementation.
  always_comb begin
    dly_in    = '0;
    dly_in[0] = full1;
    for (int t = 0; t < DLY_IN; t++) dly_in[t+1] = dly_in[t];
  end
  assign req = dly_in[DLY_IN];

  always_comb begin
    dly_free    = '0;
    dly_free[0] = rel_raw;
    for (int t = 0; t < DLY_FREE; t++) dly_free[t+1] = dly_free[t];
  end
  assign rel = dly_free[DLY_FREE];

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    logic                  ph_a, ph_b, fire_l;
    logic [DATA_WIDTH-1:0] q;

    // Held-off while i_free is high, so a pending free completes before the next drive.
    assign fire_l  = req & r_sel[k] & ~taken[k] & ~full[k] & ~bus.i_free[k];
    assign fire[k] = fire_l;
    assign full[k] = ph_a ^ ph_b;
    assign bus.o_data[k] = q;

    always_ff @(posedge fire_l or negedge rstn) begin
      if (!rstn) begin
        ph_a <= 1'b0;
        q    <= '0;
      end else begin
        ph_a <= ~ph_a;
        q    <= r_in;
      end
    end

    always_ff @(posedge bus.i_free[k] or negedge rstn) begin
      if (!rstn) ph_b <= 1'b0;
      else       ph_b <= ~ph_b;
    end

`ifdef MMU_SPLIT_BCAST_EN
    // Snapshot of ph_a at token entry; differs once this port has taken the current token.
    logic base;
    always_ff @(posedge bus.i_drive or negedge rstn) begin
      if (!rstn) base <= 1'b0;
      else       base <= ph_a;
    end
    assign taken[k] = ph_a ^ base;
`else
    assign taken[k] = 1'b0;
`endif
  end

`ifdef MMU_SPLIT_BCAST_EN
  assign rel_raw = full1 & (&(taken | ~r_sel));
`else
  assign rel_raw = |fire;
`endif

  assign bus.o_drive = full;

endmodule

// File: tb/tb_c_route_split8_mmu.sv
// Directed bench for the click splitter: unicast, sweep, back-pressure, head-of-line, reset, broadcast.
module tb_c_route_split8_mmu;

  logic clk = 1'b0;
  logic rstn;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_free_ev = 0;
  int   n_drv[8];
  logic [7:0] prev_drv = 8'h00;

  c_route_split8_mmu_if #(.NUM_PORTS(8), .DATA_WIDTH(88)) bus ();

  c_route_split8_mmu dut (.rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge bus.o_free) n_free_ev++;

  always @(bus.o_drive) begin
    for (int k = 0; k < 8; k++)
      if (bus.o_drive[k] && !prev_drv[k]) n_drv[k]++;
    prev_drv = bus.o_drive;
  end

  function automatic logic [87:0] tok(input logic [2:0] sel, input logic [7:0] tag);
    return {tag, 72'h0123_4567_89AB_CDEF_55, 5'b00000, sel};
  endfunction

  task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_free_ev = 0;
    for (int k = 0; k < 8; k++) n_drv[k] = 0;
  endtask

  task automatic drive_up(input logic [87:0] d);
    bus.i_data = d;
    step();
    bus.i_drive = 1'b1;
    step();
  endtask

  task automatic finish_up(input string tag);
    chk({tag, "_free_hi"}, 88'(bus.o_free), 88'd1);
    bus.i_drive = 1'b0;
    step();
    chk({tag, "_free_lo"}, 88'(bus.o_free), 88'd0);
  endtask

  task automatic pulse_free(input int k);
    chk("free_on_full_port", 88'(bus.o_drive[k]), 88'd1);
    bus.i_free[k] = 1'b1;
    step();
    bus.i_free[k] = 1'b0;
    step();
  endtask

  initial begin
    logic [87:0] ta, tb_, tc, t1;
    t1 = {80'hA5A5_A5A5_A5A5_A5A5_A5A5, 8'h03};

    rstn = 1'b0;
    bus.i_drive = 1'b0;
    bus.i_data  = '0;
    bus.i_free  = '0;
    step();
    chk("rst_free",  88'(bus.o_free),  88'd0);
    chk("rst_drive", 88'(bus.o_drive), 88'd0);
    chk("rst_data0", bus.o_data[0], 88'd0);
    chk("rst_data7", bus.o_data[7], 88'd0);
    rstn = 1'b1;
    step();

    // T1 unicast to port 3
    clear_counts();
    drive_up(t1);
    chk("t1_drive", 88'(bus.o_drive), 88'h08);
    chk("t1_data3", bus.o_data[3], t1);
    finish_up("t1");
    chk("t1_nfree", 88'(n_free_ev), 88'd1);
    pulse_free(3);
    chk("t1_drive_rel", 88'(bus.o_drive), 88'h00);

    // T2 sweep all ports
    clear_counts();
    for (int k = 0; k < 8; k++) begin
      ta = tok(3'(k), 8'h10 + 8'(k));
      drive_up(ta);
      chk("t2_drive", 88'(bus.o_drive), 88'(8'h01 << k));
      chk("t2_data", bus.o_data[k], ta);
      finish_up("t2");
      pulse_free(k);
    end
    chk("t2_nfree", 88'(n_free_ev), 88'd8);
    for (int k = 0; k < 8; k++) chk("t2_ndrv", 88'(n_drv[k]), 88'd1);

    // T3 back-pressure on port 5
    clear_counts();
    ta  = tok(3'd5, 8'hA1);
    tb_ = tok(3'd5, 8'hB2);
    drive_up(ta);
    finish_up("t3a");
    drive_up(tb_);
    chk("t3_stall_free", 88'(bus.o_free), 88'd0);
    chk("t3_hold_data", bus.o_data[5], ta);
    chk("t3_hold_drive", 88'(bus.o_drive), 88'h20);
    pulse_free(5);
    chk("t3_b_drive", 88'(bus.o_drive), 88'h20);
    chk("t3_b_data", bus.o_data[5], tb_);
    chk("t3_ndrv5", 88'(n_drv[5]), 88'd2);
    finish_up("t3b");
    pulse_free(5);

    // T4 head-of-line blocking
    clear_counts();
    ta  = tok(3'd2, 8'hC1);
    tb_ = tok(3'd2, 8'hC2);
    tc  = tok(3'd6, 8'hC3);
    drive_up(ta);
    finish_up("t4a");
    drive_up(tb_);
    chk("t4_stall_free", 88'(bus.o_free), 88'd0);
    chk("t4_p6_idle", 88'(n_drv[6]), 88'd0);
    pulse_free(2);
    chk("t4_b_data", bus.o_data[2], tb_);
    finish_up("t4b");
    drive_up(tc);
    chk("t4_drive", 88'(bus.o_drive), 88'h44);
    chk("t4_c_data", bus.o_data[6], tc);
    finish_up("t4c");
    chk("t4_ndrv6", 88'(n_drv[6]), 88'd1);
    pulse_free(2);
    pulse_free(6);

    // T5 reset while port 4 holds a token and a second one is stalled
    ta = tok(3'd4, 8'hD1);
    drive_up(ta);
    finish_up("t5a");
    drive_up(tok(3'd4, 8'hD2));
    clear_counts();
    rstn = 1'b0;
    step();
    chk("t5_rst_drive", 88'(bus.o_drive), 88'd0);
    chk("t5_rst_data4", bus.o_data[4], 88'd0);
    bus.i_drive = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("t5_no_free", 88'(n_free_ev), 88'd0);
    tb_ = tok(3'd4, 8'hD3);
    drive_up(tb_);
    chk("t5_drive", 88'(bus.o_drive), 88'h10);
    chk("t5_data4", bus.o_data[4], tb_);
    finish_up("t5b");
    pulse_free(4);

`ifdef MMU_SPLIT_BCAST_EN
    // T6 broadcast with port 7 busy
    ta  = tok(3'd7, 8'hE0);
    tb_ = tok(3'd0, 8'hE1) | 88'h8;
    drive_up(ta);
    finish_up("t6a");
    drive_up(tb_);
    chk("t6_drive_all", 88'(bus.o_drive), 88'hFF);
    chk("t6_wait_free", 88'(bus.o_free), 88'd0);
    for (int k = 0; k < 7; k++) pulse_free(k);
    chk("t6_no_refire", 88'(bus.o_drive), 88'h80);
    chk("t6_still_wait", 88'(bus.o_free), 88'd0);
    pulse_free(7);
    chk("t6_p7_drive", 88'(bus.o_drive), 88'h80);
    for (int k = 0; k < 8; k++) chk("t6_data", bus.o_data[k], tb_);
    finish_up("t6b");
    pulse_free(7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
